// File: rtl/rr_arb_mux.sv
// Round-robin packet arbiter feeding a single registered output stage.
// A requester that wins with a non-last beat keeps the grant until its last beat.
//
//   state  | meaning
//   IDLE   | no packet in flight; next grant searched from last_ptr+1 with wrap
//   LOCKED | mid-packet; only lock_idx may transfer until its last beat
module rr_arb_mux #(
   parameter int NUM_REQ = 10,
   parameter int DATA_W  = 32,
   localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_last,
   output logic [SRC_W-1:0]          out_src,
   input  logic                      out_ready
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t            state, state_nxt;
   logic [SRC_W-1:0]  last_ptr, lock_idx, grant_idx;
   logic              can_load, found, xfer, sel_last;
   logic [DATA_W-1:0] sel_data;

   assign can_load = !out_valid || out_ready;

   // Grant selection deliberately ignores req_data and req_last.
   always_comb begin
      grant_idx = lock_idx;
      found     = 1'b0;
      req_ready = '0;
      if (state == IDLE) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[SRC_W'((int'(last_ptr) + k) % NUM_REQ)]) begin
               found     = 1'b1;
               grant_idx = SRC_W'((int'(last_ptr) + k) % NUM_REQ);
            end
         end
      end else begin
         found = 1'b1;
      end
      if (!rst && can_load && found)
         req_ready[grant_idx] = 1'b1;
   end

   assign xfer     = |(req_valid & req_ready);
   assign sel_last = req_last[grant_idx];
   assign sel_data = req_data[int'(grant_idx)*DATA_W +: DATA_W];

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (xfer && !sel_last) state_nxt = LOCKED;
         LOCKED:  if (xfer && sel_last)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last_ptr  <= SRC_W'(NUM_REQ - 1);
         lock_idx  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_src   <= '0;
      end else begin
         state <= state_nxt;
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_src   <= grant_idx;
            if (state == IDLE)
               lock_idx <= grant_idx;
            // Priority rotates only on packet boundaries, never mid-packet.
            if (sel_last)
               last_ptr <= grant_idx;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux with four requesters and byte payloads.
// Payload of requester i is {tag, i}, so out_data identifies both beat and source.
module tb_rr_arb_mux;
   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid, req_last, req_ready;
   logic [N*W-1:0] req_data;
   logic           out_valid, out_last, out_ready;
   logic [W-1:0]   out_data;
   logic [1:0]     out_src;

   int n_assert = 0;
   int n_fail   = 0;

   rr_arb_mux #(.NUM_REQ(N), .DATA_W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic r,
                        input logic [3:0] tag);
      req_valid = v;
      req_last  = l;
      out_ready = r;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = {tag, 4'(i)};
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drive a cycle, check the combinational grant, clock it in.
   task automatic step(input string tag, input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic r, input logic [3:0] dtag, input logic [N-1:0] exp_ready);
      drive(v, l, r, dtag);
      #1;
      chk({tag, ".ready"}, 32'(req_ready), 32'(exp_ready));
      tick();
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [1:0] s,
                          input logic l, input logic [7:0] d);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".out_src"},   32'(out_src),   32'(s));
      chk({tag, ".out_last"},  32'(out_last),  32'(l));
      chk({tag, ".out_data"},  32'(out_data),  32'(d));
   endtask

   initial begin
      // Reset: outputs clear, req_ready forced low even with everyone valid.
      rst = 1'b1;
      drive(4'b1111, 4'b1111, 1'b1, 4'h0);
      #1;
      chk("rst.ready", 32'(req_ready), 32'h0);
      tick();
      tick();
      chk_out("rst", 1'b0, 2'd0, 1'b0, 8'h00);
      rst = 1'b0;

      // All valid, single-beat packets: 0,1,2,3,0 back to back.
      for (int k = 0; k < 5; k++) begin
         step("rr", 4'b1111, 4'b1111, 1'b1, 4'(k + 1), 4'(1 << (k % 4)));
         chk_out("rr", 1'b1, 2'(k % 4), 1'b1, {4'(k + 1), 4'(k % 4)});
      end

      // Req 2 sends 3 beats while 0 and 3 wait; then 3, then 0.
      step("pkt2a", 4'b1101, 4'b1001, 1'b1, 4'h6, 4'b0100);
      chk_out("pkt2a", 1'b1, 2'd2, 1'b0, 8'h62);
      step("pkt2b", 4'b1101, 4'b1001, 1'b1, 4'h7, 4'b0100);
      chk_out("pkt2b", 1'b1, 2'd2, 1'b0, 8'h72);
      step("pkt2c", 4'b1101, 4'b1101, 1'b1, 4'h8, 4'b0100);
      chk_out("pkt2c", 1'b1, 2'd2, 1'b1, 8'h82);
      step("after2", 4'b1101, 4'b1101, 1'b1, 4'h9, 4'b1000);
      chk_out("after2", 1'b1, 2'd3, 1'b1, 8'h93);
      step("after3", 4'b1101, 4'b1101, 1'b1, 4'hA, 4'b0001);
      chk_out("after3", 1'b1, 2'd0, 1'b1, 8'hA0);

      // Backpressure for 5 cycles: output holds, no grants; then drain+reload.
      for (int j = 0; j < 5; j++) begin
         step("stall", 4'b1111, 4'b1111, 1'b0, 4'hB, 4'b0000);
         chk_out("stall", 1'b1, 2'd0, 1'b1, 8'hA0);
      end
      step("reload", 4'b1111, 4'b1111, 1'b1, 4'hC, 4'b0010);
      chk_out("reload", 1'b1, 2'd1, 1'b1, 8'hC1);

      // Lock on req 1, which then goes quiet for 2 cycles while req 0 waits.
      step("pre1", 4'b0001, 4'b1111, 1'b1, 4'hD, 4'b0001);
      chk_out("pre1", 1'b1, 2'd0, 1'b1, 8'hD0);
      step("lock1", 4'b0011, 4'b1101, 1'b1, 4'hE, 4'b0010);
      chk_out("lock1", 1'b1, 2'd1, 1'b0, 8'hE1);
      for (int j = 0; j < 2; j++) begin
         drive(4'b0001, 4'b1111, 1'b1, 4'hF);
         #1;
         chk("gap.ready_others", 32'(req_ready & 4'b1101), 32'h0);
         tick();
         chk("gap.out_valid", 32'(out_valid), 32'h0);
      end
      step("end1", 4'b0011, 4'b1111, 1'b1, 4'h1, 4'b0010);
      chk_out("end1", 1'b1, 2'd1, 1'b1, 8'h11);
      step("then0", 4'b0001, 4'b1111, 1'b1, 4'h2, 4'b0001);
      chk_out("then0", 1'b1, 2'd0, 1'b1, 8'h20);

      // Reset while locked on req 3 abandons the lock.
      step("lock3", 4'b1000, 4'b0111, 1'b1, 4'h3, 4'b1000);
      chk_out("lock3", 1'b1, 2'd3, 1'b0, 8'h33);
      rst = 1'b1;
      drive(4'b1111, 4'b1111, 1'b1, 4'h4);
      #1;
      chk("midrst.ready", 32'(req_ready), 32'h0);
      tick();
      rst = 1'b0;
      chk_out("midrst", 1'b0, 2'd0, 1'b0, 8'h00);
      step("postrst", 4'b1111, 4'b1111, 1'b1, 4'h5, 4'b0001);
      chk_out("postrst", 1'b1, 2'd0, 1'b1, 8'h50);

      // Wrap-around: req 3 then req 0 with no bubble.
      step("wrap3", 4'b1000, 4'b1111, 1'b1, 4'h6, 4'b1000);
      chk_out("wrap3", 1'b1, 2'd3, 1'b1, 8'h63);
      step("wrap0", 4'b0001, 4'b1111, 1'b1, 4'h7, 4'b0001);
      chk_out("wrap0", 1'b1, 2'd0, 1'b1, 8'h70);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
